// File: rtl/addatone_pkg.sv
// Shared constants, state encoding and output saturation for the additive
// synthesis control path (harmonic_sequencer and the Adder it drives).
package addatone_pkg;

  localparam int SINE_ADDR_BITS     = 10;
  localparam int SINE_DEPTH         = 1 << SINE_ADDR_BITS;
  localparam int SINE_WIDTH         = 16;
  localparam int SINE_PEAK          = 32767;
  localparam int ADDER_DIVISOR_BITS = 9;
  localparam int MULT_MAX           = (1 << ADDER_DIVISOR_BITS) - 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_START  = 3'd3,
    ST_ARM    = 3'd4,
    ST_WAIT   = 3'd5,
    ST_FINISH = 3'd6
  } seq_state_t;

  function automatic logic signed [15:0] saturate16(input logic signed [31:0] value);
    if (value > 32'sd32767) return 16'sh7fff;
    if (value < -32'sd32768) return 16'sh8000;
    return $signed(value[15:0]);
  endfunction

endpackage

// File: rtl/harmonic_sequencer_sine_lut.sv
// Registered full-wave signed sine ROM with one cycle of latency. Contents
// come from a Bhaskara rational approximation (peak error about 0.2%).
module sine_lut
  import addatone_pkg::*;
#(
  parameter int ADDR_BITS = SINE_ADDR_BITS
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset_N,
  input  logic [ADDR_BITS-1:0]         i_Addr,
  output logic signed [SINE_WIDTH-1:0] o_Data
);

  localparam longint HALF = longint'(1) << (ADDR_BITS - 1);
  localparam longint KNEE = (5 * HALF * HALF) / 4;

  // The top address bit selects the negative half cycle; the rest is the
  // position within the half, where sin ~= 4q / (KNEE - q), q = p * (HALF - p).
  function automatic logic signed [SINE_WIDTH-1:0] sine_at(input logic [ADDR_BITS-1:0] addr);
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] mag;
    logic signed [SINE_WIDTH-1:0] s;
    p   = 64'(addr[ADDR_BITS-2:0]);
    q   = p * (64'(HALF) - p);
    mag = (64'(4 * SINE_PEAK) * q) / (64'(KNEE) - q);
    s   = SINE_WIDTH'(mag);
    return addr[ADDR_BITS-1] ? -s : s;
  endfunction

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) o_Data <= '0;
    else            o_Data <= sine_at(i_Addr);
  end

endmodule

// File: rtl/harmonic_sequencer.sv
// Per sample-rate strobe, walks harmonics 1..N of the fundamental, feeding
// sine sample / level pairs to the Adder and emitting the saturated sum.
module harmonic_sequencer
  import addatone_pkg::*;
#(
  parameter int HARMONICS     = 16,
  parameter int LUT_ADDR_BITS = SINE_ADDR_BITS,
  parameter int DIVISOR_BITS  = ADDER_DIVISOR_BITS,
  parameter int OUT_SHIFT     = 2
) (
  input  logic               i_Clock,
  input  logic               i_Reset_N,
  input  logic               i_Sample_Clock,
  input  logic [31:0]        i_Freq_Inc,
  input  logic [4:0]         i_Harmonic_Count,
  input  logic [8:0]         i_Decay,
  input  logic               i_Adder_Done,
  input  logic signed [31:0] i_Accumulator,
  output logic               o_Adder_Start,
  output logic               o_Adder_Clear,
  output logic signed [15:0] o_Multiple,
  output logic signed [15:0] o_Sample,
  output logic signed [15:0] o_Out_Sample,
  output logic               o_Out_Valid,
  output logic               o_Busy,
  output logic               o_Overrun
);

  localparam logic [15:0] MULT_START = 16'((1 << DIVISOR_BITS) - 1);
  localparam logic [4:0]  COUNT_MAX  = 5'(HARMONICS);

  seq_state_t state, state_d;

  logic [31:0]        fund_phase, fund_next, fund_base;
  logic [31:0]        harm_phase, harm_phase_d;
  logic [31:0]        harm_inc, freq_inc_q;
  logic [32:0]        harm_inc_sum;
  logic [15:0]        mult, mult_next;
  logic [8:0]         decay_q;
  logic [4:0]         count_q, count_in, index;
  logic               strobe_idle, step_done, stop;
  logic signed [15:0] rom_data;
  logic signed [31:0] acc_shifted;

  assign fund_next    = fund_phase + i_Freq_Inc;
  assign strobe_idle  = (state == ST_IDLE) && i_Sample_Clock;
  assign step_done    = (state == ST_WAIT) && i_Adder_Done;
  assign harm_inc_sum = {1'b0, harm_inc} + {1'b0, freq_inc_q};
  assign mult_next    = (mult > {7'd0, decay_q}) ? (mult - {7'd0, decay_q}) : 16'd0;
  assign acc_shifted  = i_Accumulator >>> OUT_SHIFT;
  // Carry-out or bit 31 of the next increment means the next harmonic is at or past Nyquist.
  assign stop         = ((index + 5'd1) == count_q) || (mult_next == 16'd0) ||
                        (harm_inc_sum[32:31] != 2'b00);

  always_comb begin
    count_in = i_Harmonic_Count;
    if (i_Harmonic_Count == 5'd0)           count_in = 5'd1;
    else if (i_Harmonic_Count > COUNT_MAX)  count_in = COUNT_MAX;
  end

  // The ROM is addressed from the next phase so its data is ready during LOOKUP.
  always_comb begin
    harm_phase_d = harm_phase;
    if (strobe_idle)    harm_phase_d = fund_next;
    else if (step_done) harm_phase_d = harm_phase + fund_base;
  end

  sine_lut #(.ADDR_BITS(LUT_ADDR_BITS)) u_sine_lut (
    .i_Clock   (i_Clock),
    .i_Reset_N (i_Reset_N),
    .i_Addr    (harm_phase_d[31 -: LUT_ADDR_BITS]),
    .o_Data    (rom_data)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) state <= ST_IDLE;
    else            state <= state_d;
  end

  // Adder handshake: o_Adder_Start is a one-cycle pulse with o_Sample/o_Multiple
  // valid alongside it; i_Adder_Done is stale in ARM and is honoured only in WAIT.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (i_Sample_Clock) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_START;
      ST_START:  state_d = ST_ARM;
      ST_ARM:    state_d = ST_WAIT;
      ST_WAIT:   if (i_Adder_Done) state_d = stop ? ST_FINISH : ST_LOOKUP;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      fund_phase    <= '0;
      fund_base     <= '0;
      harm_phase    <= '0;
      harm_inc      <= '0;
      freq_inc_q    <= '0;
      mult          <= '0;
      decay_q       <= '0;
      count_q       <= '0;
      index         <= '0;
      o_Adder_Start <= 1'b0;
      o_Adder_Clear <= 1'b0;
      o_Multiple    <= '0;
      o_Sample      <= '0;
      o_Out_Sample  <= '0;
      o_Out_Valid   <= 1'b0;
      o_Busy        <= 1'b0;
      o_Overrun     <= 1'b0;
    end else begin
      o_Adder_Clear <= strobe_idle;
      o_Adder_Start <= (state == ST_LOOKUP);
      o_Out_Valid   <= (state == ST_FINISH);
      o_Busy        <= (state_d != ST_IDLE);
      harm_phase    <= harm_phase_d;
      // Pitch keeps advancing on every strobe, even one that overruns.
      if (i_Sample_Clock) fund_phase <= fund_next;
      if (i_Sample_Clock && (state != ST_IDLE)) o_Overrun <= 1'b1;
      if (strobe_idle) begin
        fund_base  <= fund_next;
        harm_inc   <= i_Freq_Inc;
        freq_inc_q <= i_Freq_Inc;
        mult       <= MULT_START;
        decay_q    <= i_Decay;
        count_q    <= count_in;
        index      <= '0;
      end
      if (state == ST_LOOKUP) begin
        o_Sample   <= rom_data;
        o_Multiple <= $signed(mult);
      end
      if (step_done) begin
        index    <= index + 5'd1;
        harm_inc <= harm_inc_sum[31:0];
        mult     <= mult_next;
      end
      if (state == ST_FINISH) o_Out_Sample <= saturate16(acc_shifted);
    end
  end

endmodule

// File: tb/tb_harmonic_sequencer.sv
// Scoreboard bench for harmonic_sequencer with a behavioural Adder and a
// reference model that derives each sample's harmonic list from phase arithmetic.
module tb_harmonic_sequencer;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_Sample_Clock = 1'b0;
  logic [31:0]        i_Freq_Inc = '0;
  logic [4:0]         i_Harmonic_Count = '0;
  logic [8:0]         i_Decay = '0;
  logic               adder_done;
  logic signed [31:0] acc_m;
  logic               o_Adder_Start, o_Adder_Clear, o_Out_Valid, o_Busy, o_Overrun;
  logic signed [15:0] o_Multiple, o_Sample, o_Out_Sample;

  harmonic_sequencer dut (
    .i_Clock          (clk),
    .i_Reset_N        (rst_n),
    .i_Sample_Clock   (i_Sample_Clock),
    .i_Freq_Inc       (i_Freq_Inc),
    .i_Harmonic_Count (i_Harmonic_Count),
    .i_Decay          (i_Decay),
    .i_Adder_Done     (adder_done),
    .i_Accumulator    (acc_m),
    .o_Adder_Start    (o_Adder_Start),
    .o_Adder_Clear    (o_Adder_Clear),
    .o_Multiple       (o_Multiple),
    .o_Sample         (o_Sample),
    .o_Out_Sample     (o_Out_Sample),
    .o_Out_Valid      (o_Out_Valid),
    .o_Busy           (o_Busy),
    .o_Overrun        (o_Overrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_mult_q[$];
  logic [9:0]  exp_addr_q[$];
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] model_fund = '0;
  int unsigned strobe_cyc = 0;
  int          starts_seen = 0;
  logic        force_en = 1'b0;
  logic signed [31:0] force_val = '0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event not expected or not seen in time (cycle %0d)", name, cyc);
  endtask

  task automatic check_sine(input logic signed [15:0] act, input logic [9:0] addr);
    real ideal;
    real diff;
    ideal = 32767.0 * $sin(6.283185307179586 * real'(addr) / 1024.0);
    diff  = real'(act) - ideal;
    if (diff < 0.0) diff = -diff;
    n_cmp++;
    if (diff > 80.0) begin
      n_fail++;
      $display("FAIL sine_sample: got %0d, expected about %0d for phase index %0d", act, $rtoi(ideal), addr);
    end
  endtask

  function automatic logic signed [15:0] ref_out(input logic signed [31:0] acc);
    longint a;
    a = longint'(acc) >>> 2;
    if (a > 32767)  return 16'sh7fff;
    if (a < -32768) return 16'sh8000;
    return 16'(a);
  endfunction

  // ---------------- behavioural Adder ----------------
  logic               pend;
  logic signed [31:0] s_m, m_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adder_done <= 1'b0;
      acc_m      <= '0;
      pend       <= 1'b0;
      s_m        <= '0;
      m_m        <= '0;
    end else begin
      if (o_Adder_Clear) acc_m <= '0;
      if (o_Adder_Start) begin
        adder_done <= 1'b0;
        pend       <= 1'b1;
        s_m        <= o_Sample;
        m_m        <= o_Multiple;
      end else if (pend) begin
        adder_done <= 1'b1;
        pend       <= 1'b0;
        acc_m      <= force_en ? force_val : acc_m + ((s_m * m_m) >>> 9);
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [31:0] n;
    if (!rst_n) begin
      exp_mult_q.delete();
      exp_addr_q.delete();
      exp_q.delete();
      starts_seen = 0;
    end else begin
      if (o_Adder_Clear) check("clear_latency", 64'(cyc - strobe_cyc), 1);
      if (o_Adder_Start) begin
        starts_seen++;
        if (exp_mult_q.size() == 0) flag("unexpected_start");
        else begin
          check("multiple", o_Multiple, exp_mult_q.pop_front());
          check_sine(o_Sample, exp_addr_q.pop_front());
        end
      end
      if (o_Out_Valid) begin
        if (exp_q.size() == 0) flag("unexpected_valid");
        else begin
          n = exp_q.pop_front();
          check("start_count", starts_seen, n);
          check("valid_latency", 64'(cyc - strobe_cyc), 3 + 4 * n);
          check("out_sample", o_Out_Sample, ref_out(acc_m));
          exp_mult_q.delete();
          exp_addr_q.delete();
        end
        starts_seen = 0;
      end
    end
  end

  // ---------------- reference model and drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic predict(input logic [31:0] inc, input logic [4:0] cnt, input logic [8:0] dec);
    int n;
    int m;
    int starts;
    logic [31:0] ph;
    n = (cnt == 0) ? 1 : ((cnt > 16) ? 16 : int'(cnt));
    m = 511;
    starts = 0;
    for (int k = 1; k <= n; k++) begin
      if (k > 1 && (m <= 0 || longint'(inc) * k >= 64'h8000_0000)) break;
      ph = 32'(longint'(model_fund) * k);
      exp_mult_q.push_back(16'(m));
      exp_addr_q.push_back(ph[31:22]);
      starts++;
      m -= int'(dec);
    end
    exp_q.push_back(32'(starts));
  endtask

  task automatic issue(input logic [31:0] inc, input logic [4:0] cnt, input logic [8:0] dec);
    int guard = 0;
    while (o_Busy && guard < 200) begin
      tick();
      guard++;
    end
    if (o_Busy) flag("busy_timeout");
    i_Freq_Inc       = inc;
    i_Harmonic_Count = cnt;
    i_Decay          = dec;
    i_Sample_Clock   = 1'b1;
    model_fund       = model_fund + inc;
    predict(inc, cnt, dec);
    strobe_cyc = cyc;
    tick();
    i_Sample_Clock = 1'b0;
  endtask

  task automatic strobe_overrun(input logic [31:0] inc);
    i_Freq_Inc     = inc;
    i_Sample_Clock = 1'b1;
    model_fund     = model_fund + inc;
    tick();
    i_Sample_Clock = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      tick();
      guard++;
    end
    if (exp_q.size() != 0) flag("valid_timeout");
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_sample"}, o_Out_Sample, 0);
    check({tag, "_out_valid"}, o_Out_Valid, 0);
    check({tag, "_busy"}, o_Busy, 0);
    check({tag, "_overrun"}, o_Overrun, 0);
    check({tag, "_start"}, o_Adder_Start, 0);
    check({tag, "_clear"}, o_Adder_Clear, 0);
    check({tag, "_multiple"}, o_Multiple, 0);
    check({tag, "_sample"}, o_Sample, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    issue(32'h0400_0000, 5'd1, 9'd0);     wait_done();
    issue(32'h0100_0000, 5'd4, 9'd100);   wait_done();
    issue(32'h3000_0000, 5'd8, 9'd10);    wait_done();
    issue(32'h0080_0000, 5'd4, 9'd300);   wait_done();

    force_en  = 1'b1;
    force_val = 32'sh0004_0000;
    issue(32'h0100_0000, 5'd2, 9'd50);    wait_done();
    force_val = -32'sh0004_0000;
    issue(32'h0100_0000, 5'd2, 9'd50);    wait_done();
    force_en  = 1'b0;

    check("overrun_before", o_Overrun, 0);
    issue(32'h0200_0000, 5'd4, 9'd20);
    tick(); tick();
    check("busy_mid_sample", o_Busy, 1);
    strobe_overrun(32'h0200_0000);
    check("overrun_set", o_Overrun, 1);
    wait_done();
    check("overrun_sticky", o_Overrun, 1);
    issue(32'h0200_0000, 5'd3, 9'd20);    wait_done();

    issue(32'h0010_0000, 5'd0, 9'd5);     wait_done();
    issue(32'h0010_0000, 5'd31, 9'd0);    wait_done();

    for (int i = 0; i < 16; i++) begin
      logic [31:0] inc;
      inc = $urandom >> $urandom_range(0, 8);
      issue(inc, 5'($urandom_range(0, 31)), 9'($urandom_range(0, 200)));
      wait_done();
    end

    issue(32'h0100_0000, 5'd16, 9'd10);
    repeat (8) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    tick(); tick();
    model_fund = '0;
    rst_n = 1'b1;
    tick();
    issue(32'h0400_0000, 5'd3, 9'd50);    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/harmonic_sequencer.md
Name: harmonic_sequencer

Overview:
- Upstream control stage for Adder; builds one additive output sample per sample-rate strobe.
- Per sample: advances the fundamental phase, then walks harmonics 1..N.
- Per harmonic: looks up a sine sample, computes a decaying level multiple, and hands the pair to Adder with a start/done handshake.
- After the last harmonic: scales and saturates Adder's accumulator to a 16-bit output sample with a one-cycle valid pulse.

Parameters:
- HARMONICS, 16: maximum harmonics per sample (i_Harmonic_Count clamped to this).
- LUT_ADDR_BITS, 10: sine ROM address width; address = top bits of harmonic phase.
- DIVISOR_BITS, 9: must match Adder; fundamental multiple = 2^DIVISOR_BITS-1 (511).
- OUT_SHIFT, 2: arithmetic right shift applied to accumulator before saturation.

Ports:
- i_Clock  in  1  system clock.
- i_Reset_N  in  1  reset, asynchronous, active-low.
- i_Sample_Clock  in  1  one-cycle sample-rate strobe.
- i_Freq_Inc  in  32  fundamental phase increment per sample.
- i_Harmonic_Count  in  5  harmonics requested; 0 treated as 1.
- i_Decay  in  9  multiple decrement per successive harmonic.
- i_Adder_Done  in  1  Adder o_Done.
- i_Accumulator  in  32 signed  Adder o_Accumulator.
- o_Adder_Start  out  1  one-cycle start pulse to Adder.
- o_Adder_Clear  out  1  one-cycle accumulator clear to Adder.
- o_Multiple  out  16 signed  level multiple to Adder.
- o_Sample  out  16 signed  sine sample to Adder.
- o_Out_Sample  out  16 signed  finished output sample.
- o_Out_Valid  out  1  one-cycle pulse when o_Out_Sample updates.
- o_Busy  out  1  high in every state except IDLE.
- o_Overrun  out  1  sticky: strobe arrived while busy.

Behaviour:
- Reset (async, i_Reset_N low):
  - All outputs 0; fundamental phase, harmonic registers and index cleared; state IDLE.
  - Reset mid-operation abandons the sample with no valid pulse. Adder is reset from the same net (inverted at top level).
- All outputs are registered.
- States: IDLE, CLEAR, LOOKUP, START, ARM, WAIT, FINISH.
- IDLE, on i_Sample_Clock:
  - fund_phase += i_Freq_Inc.
  - harm_phase <= new fund_phase; harm_inc <= i_Freq_Inc; mult <= 511; index <= 0.
  - Latch count, clamped to 1..HARMONICS.
  - -> CLEAR.
- CLEAR: o_Adder_Clear high this cycle; -> LOOKUP.
- LOOKUP: sine_lut address = harm_phase[31:32-LUT_ADDR_BITS]; 1-cycle ROM latency; -> START.
- START: o_Sample <= ROM data; o_Multiple <= mult; o_Adder_Start high this cycle; -> ARM.
- ARM: ignore i_Adder_Done, which is still stale-high this cycle; -> WAIT.
- WAIT: hold until i_Adder_Done = 1, then:
  - index += 1; harm_phase += fund_phase; harm_inc += i_Freq_Inc (33-bit sum).
  - mult <= max(mult - i_Decay, 0).
  - Stop (-> FINISH) if any of: index+1 == count; new mult == 0; new harm_inc >= 2^31 (Nyquist, including carry-out).
  - Otherwise -> LOOKUP.
- FINISH:
  - o_Out_Sample <= saturate16(i_Accumulator >>> OUT_SHIFT), clipping to +32767 / -32768.
  - o_Out_Valid pulses the following cycle; -> IDLE.
- Timing: strobe at cycle 0 -> CLEAR cycle 1; harmonic k occupies cycles 2+4k..5+4k; FINISH at 2+4N; o_Out_Valid at 3+4N.
- Fundamental is always rendered; the Nyquist check applies only to harmonics 2 and up.
- Overrun: i_Sample_Clock while not IDLE
  - sets o_Overrun (sticky until reset);
  - fund_phase still advances, to keep pitch;
  - current sample is not restarted.
- Strobe coincident with FINISH counts as overrun.
- i_Freq_Inc, i_Decay and count are sampled only at IDLE->CLEAR, except fund increment accumulation in WAIT, which uses a latched copy.

Decomposition:
- Shared package addatone_pkg holds: state encoding constants; sine ROM width/depth constants; MULT_MAX = 2^DIVISOR_BITS-1.
- One sub-module: sine_lut — registered full-wave 16-bit signed ROM, 2^LUT_ADDR_BITS entries, 1-cycle latency.

Test Plan:
- Bench uses a behavioural Adder model: done low for one cycle after start, then accumulator updated alongside done high.
- Reset during WAIT -> all outputs 0 immediately, o_Busy 0, no o_Out_Valid; next strobe runs normally.
- count=1, inc=0x0400_0000 -> one start pulse, o_Multiple=511, o_Out_Valid at cycle 7 after strobe.
- count=4, decay=100 -> multiples 511, 411, 311, 211; four starts; o_Out_Valid at cycle 19.
- inc=0x3000_0000, count=8 -> harm_inc reaches 0x9000_0000 at harmonic 3, so only 2 starts are issued.
- decay=300, count=4 -> multiples 511, 211; mult saturates to 0, so 2 starts only.
- Accumulator 0x0004_0000 -> o_Out_Sample 0x7FFF; accumulator -0x0004_0000 -> 0x8000; second strobe while busy -> o_Overrun=1 and fund_phase advanced twice.
